// File: rtl/four_bank_mem_resp.sv
// Four-way word-interleaved banked memory responder: one request per cycle,
// per-bank busy window, read data returned two cycles after acceptance.

module four_bank_mem_resp_bank #(
    parameter int BANK_LAT = 4,
    parameter int IDX_W    = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    output logic             busy
);
    localparam logic [3:0] LAT = 4'(BANK_LAT);

    logic [15:0] mem [0:(1<<IDX_W)-1];
    logic [3:0]  cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (acc)
            cnt <= LAT;
        else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    // Array is never reset so contents survive rst_n; rdata is pipeline stage 1.
    always_ff @(posedge clk) begin
        if (acc && we)
            mem[idx] <= wdata;
        if (acc && !we)
            rdata <= mem[idx];
    end

    assign busy = (cnt != 4'd0);
endmodule

module four_bank_mem_resp #(
    parameter int BANK_LAT = 4,
    parameter int IDX_W    = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);
    localparam int NUM_BANKS = 4;
    localparam int STAGES    = 2;

    logic                          req;
    logic                          acc;
    logic [1:0]                    bank;
    logic [NUM_BANKS-1:0][15:0]    bank_rd;
    logic [STAGES:1]               vld_pipe;
    logic [1:0]                    s1_bank;
    logic [15:0]                   s2_data;

    assign req   = rd | wr;
    assign bank  = addr[2:1];
    assign err   = req && ((rd && wr) || addr[0]);
    assign stall = req && busy[bank];
    assign acc   = rst_n && req && !err && !busy[bank];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        four_bank_mem_resp_bank #(
            .BANK_LAT(BANK_LAT),
            .IDX_W   (IDX_W)
        ) u_bank (
            .clk  (clk),
            .rst_n(rst_n),
            .acc  (acc && (bank == 2'(b))),
            .we   (wr),
            .idx  (addr[3 +: IDX_W]),
            .wdata(data_in),
            .rdata(bank_rd[b]),
            .busy (busy[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[1], acc && rd};
    end

    // The source bank stays busy past stage 2 capture, so its rdata is stable here.
    always_ff @(posedge clk) begin
        if (acc && rd)
            s1_bank <= bank;
        s2_data <= bank_rd[s1_bank];
    end

    assign data_out = vld_pipe[STAGES] ? s2_data : 16'd0;
endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Bench for four_bank_mem_resp: vector table, directed corner sequences and
// random traffic, all checked against a cycle-level reference model.

module tb_four_bank_mem_resp;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr, data_in, data_out;
    logic        rd, wr, stall, err;
    logic [3:0]  busy;

    four_bank_mem_resp #(.BANK_LAT(LAT), .IDX_W(13)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .rd(rd), .wr(wr), .data_out(data_out), .stall(stall),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: last busy cycle per bank, word store, scheduled returns.
    typedef struct { int cyc; logic [15:0] d; } ret_t;
    int          cur;
    int          busy_until [4];
    logic [15:0] mmem [int];
    ret_t        rq [$];
    int          nret;

    logic        s_stall, s_err;
    logic [3:0]  s_busy;
    logic [15:0] s_data;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cur);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic rn);
        logic [3:0]  eb;
        logic [15:0] ed;
        logic        rq_p, e_err;
        int          b, key;
        ret_t        t;
        rd = r; wr = w; addr = a; data_in = d; rst_n = rn;
        b     = int'(a[2:1]);
        key   = int'(a[15:1]);
        rq_p  = r | w;
        e_err = rq_p && ((r && w) || a[0]);
        for (int k = 0; k < 4; k++) eb[k] = (cur <= busy_until[k]);
        ed = (rq.size() > 0 && rq[0].cyc == cur) ? rq[0].d : 16'h0;
        @(negedge clk);
        s_stall = stall; s_err = err; s_busy = busy; s_data = data_out;
        chk("busy", 16'(busy), 16'(eb));
        chk("stall", 16'(stall), 16'(rq_p && eb[b]));
        chk("err", 16'(err), 16'(e_err));
        chk("data_out", data_out, ed);
        if (data_out != 16'h0) nret++;
        @(posedge clk);
        if (!rn) begin
            for (int k = 0; k < 4; k++) busy_until[k] = cur;
            rq.delete();
        end else if (rq_p && !e_err && !eb[b]) begin
            busy_until[b] = cur + LAT;
            if (w) mmem[key] = d;
            else if (mmem.exists(key)) begin
                t.cyc = cur + 2; t.d = mmem[key];
                rq.push_back(t);
            end
        end
        while (rq.size() > 0 && rq[0].cyc <= cur) void'(rq.pop_front());
        cur++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    typedef struct {
        logic rd, wr, rn;
        logic [15:0] addr, din;
        logic st, er;
        logic [3:0] bz;
        logic [15:0] dat;
    } vec_t;
    vec_t tbl [14];

    logic [15:0] pool [8];
    logic [3:0]  lf_busy [6];
    logic [15:0] lf_data [6];
    int          nstall;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 4'b0000, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 4'b0001, 16'h0000};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[2];
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0001, 16'h0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0001, 16'hBEEF};
        tbl[9]  = tbl[7];
        tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, 4'b0001, 16'h0000};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1, 4'b0000, 16'h0000};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h0000};
        tbl[13] = tbl[12];

        rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cur = 0; nret = 0;
        for (int k = 0; k < 4; k++) busy_until[k] = -1;

        // Reset, write then read with stall window, and error vectors.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].rn);
            chk($sformatf("vec%0d_busy", i), 16'(s_busy), 16'(tbl[i].bz));
            chk($sformatf("vec%0d_stall", i), 16'(s_stall), 16'(tbl[i].st));
            chk($sformatf("vec%0d_err", i), 16'(s_err), 16'(tbl[i].er));
            chk($sformatf("vec%0d_data", i), s_data, tbl[i].dat);
        end

        // Odd-address write must not disturb the even neighbour.
        step(1'b0, 1'b1, 16'h0202, 16'hA5A5, 1'b1); idle(LAT);
        step(1'b0, 1'b1, 16'h0203, 16'h1111, 1'b1);
        step(1'b1, 1'b0, 16'h0202, 16'h0, 1'b1); idle(2);
        chk("odd_wr_neighbour", s_data, 16'hA5A5);
        idle(LAT);

        // Line fill across all four banks.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 16'h0120 + 16'(2*k), 16'hC000 + 16'(k), 1'b1);
        end
        idle(LAT + 1);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) step(1'b1, 1'b0, 16'h0120 + 16'(2*k), 16'h0, 1'b1);
            else       idle(1);
            lf_busy[k] = s_busy;
            lf_data[k] = s_data;
            if (k < 4) chk($sformatf("fill_stall%0d", k), 16'(s_stall), 16'h0);
        end
        chk("fill_busy1", 16'(lf_busy[1]), 16'h0001);
        chk("fill_busy2", 16'(lf_busy[2]), 16'h0003);
        chk("fill_busy3", 16'(lf_busy[3]), 16'h0007);
        chk("fill_busy4", 16'(lf_busy[4]), 16'h000F);
        for (int k = 2; k < 6; k++) chk($sformatf("fill_data%0d", k), lf_data[k], 16'hC000 + 16'(k - 2));
        idle(LAT);

        // Same-bank conflict: second read held until the window closes.
        step(1'b0, 1'b1, 16'h0000, 16'hDEAD, 1'b1); idle(LAT);
        step(1'b0, 1'b1, 16'h0008, 16'hFACE, 1'b1); idle(LAT);
        nret = 0; nstall = 0;
        step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b1);
        for (int i = 0; i < 2 * LAT + 4; i++) begin
            step(1'b1, 1'b0, 16'h0008, 16'h0, 1'b1);
            if (!s_stall) break;
            nstall++;
        end
        idle(LAT + 2);
        chk("conflict_stalls", 16'(nstall), 16'(LAT));
        chk("conflict_returns", 16'(nret), 16'd2);

        // Reset mid-read drops the return but keeps memory contents.
        step(1'b0, 1'b1, 16'h0300, 16'h1234, 1'b1); idle(LAT);
        step(1'b1, 1'b0, 16'h0300, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(1);
        chk("rst_mid_busy", 16'(s_busy), 16'h0);
        chk("rst_mid_data", s_data, 16'h0);
        step(1'b1, 1'b0, 16'h0300, 16'h0, 1'b1); idle(2);
        chk("rst_keep_data", s_data, 16'h1234);
        idle(LAT);

        // Random traffic over a prefilled address pool.
        pool[0] = 16'h0040; pool[1] = 16'h0042; pool[2] = 16'h0044; pool[3] = 16'h0046;
        pool[4] = 16'h1000; pool[5] = 16'h1002; pool[6] = 16'hFFFE; pool[7] = 16'h2006;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, pool[k], 16'($urandom), 1'b1);
            idle(LAT);
        end
        for (int i = 0; i < 600; i++) begin
            int          kind;
            logic [15:0] a;
            logic        rn;
            kind = int'($urandom_range(0, 99));
            a    = pool[$urandom_range(0, 7)];
            rn   = ($urandom_range(0, 63) != 0);
            if (kind < 45)      step(1'b1, 1'b0, a, 16'h0, rn);
            else if (kind < 80) step(1'b0, 1'b1, a, 16'($urandom), rn);
            else if (kind < 85) step(1'b1, 1'b1, a, 16'($urandom), rn);
            else if (kind < 90) step(1'b1, 1'b0, a | 16'h0001, 16'h0, rn);
            else                step(1'b0, 1'b0, a, 16'h0, rn);
        end
        idle(LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
